vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/vga_axis_counter.sv | 68 ++++++
 rtl/vga_timing_gen.sv | 140 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants for the VGA raster timing generator.
//   - Default 640x480@60 line and frame geometry (25 MHz pixel clock).
//   - Sync polarity encodings used by the H_POL / V_POL parameters.
// No ports: this is a package.
// ----------------------------------------------------------------------------
package vga_timing_pkg;

    // Horizontal geometry, in pixels
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    // Vertical geometry, in lines
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Counter / coordinate width wide enough for both default totals
    localparam int DEF_CW = 10;

    // Level driven on a sync pin while the sync pulse is active
    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

endpackage

// File: rtl/vga_axis_counter.sv
// ----------------------------------------------------------------------------
// vga_axis_counter
// One raster axis (horizontal or vertical). Counts 0..TOTAL-1 while step is
// high and decodes the region the current count falls in.
// Region order within one period: active, front porch, sync, back porch.
// Ports:
//   clk_25     in   pixel clock
//   reset_n    in   synchronous active-low reset (count returns to 0)
//   step       in   advance the count by one position
//   cnt        out  current position, CW bits
//   wrap       out  current position is the last one (TOTAL-1)
//   in_active  out  current position is inside the visible region
//   in_sync    out  current position is inside the sync pulse
// ----------------------------------------------------------------------------
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int CW     = DEF_CW
) (
    input  logic          clk_25,
    input  logic          reset_n,
    input  logic          step,
    output logic [CW-1:0] cnt,
    output logic          wrap,
    output logic          in_active,
    output logic          in_sync
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    // Elaboration-time sanity checks on the geometry
    if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1 || CW < 1) begin : g_bad_width
        $error("vga_axis_counter: every region width and CW must be >= 1");
    end
    if (TOTAL > (2 ** CW)) begin : g_bad_cw
        $error("vga_axis_counter: TOTAL does not fit in CW bits");
    end

    // Region boundaries. BP >= 1 guarantees every boundary is below TOTAL,
    // so each fits in CW bits even when TOTAL == 2**CW.
    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);
    localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == LAST);

    always_ff @(posedge clk_25) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (step) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

    assign cnt       = r_cnt;
    assign wrap      = w_wrap;
    assign in_active = (r_cnt < ACT_END);
    assign in_sync   = (r_cnt >= SYNC_START) && (r_cnt < SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing generator on the 25 MHz pixel clock. Two axis counters
// track the raster position; every output is a registered decode of that
// position, so all outputs share exactly one cycle of latency.
// Ports:
//   clk_25       in   pixel clock
//   reset_n      in   synchronous active-low reset
//   en           in   advance enable; 0 freezes counters and outputs
//   h_sync       out  horizontal sync, active level H_POL
//   v_sync       out  vertical sync, active level V_POL
//   de           out  display enable (visible area)
//   x, y         out  pixel column/row, forced to 0 outside the visible area
//   line_start   out  high for position h=0 of every line
//   frame_start  out  high for position (0,0)
// The strobes are held along with everything else while en=0, so a consumer
// must qualify them with en.
// ----------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit H_POL    = SYNC_ACTIVE_LOW,
    parameter bit V_POL    = SYNC_ACTIVE_LOW,
    parameter int CW       = DEF_CW
) (
    input  logic          clk_25,
    input  logic          reset_n,
    input  logic          en,
    output logic          h_sync,
    output logic          v_sync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    logic [CW-1:0] w_h_cnt;
    logic [CW-1:0] w_v_cnt;
    logic          w_h_wrap;
    logic          w_h_active;
    logic          w_h_in_sync;
    logic          w_v_active;
    logic          w_v_in_sync;
    logic          w_v_step;
    // The end of frame is already visible as the (0,0) decode that follows it,
    // so the vertical wrap flag has no consumer here.
    logic          w_v_wrap_unused;

    // The vertical axis moves once per line, on the last pixel of the line,
    // so v_sync can only change in step with h position 0.
    assign w_v_step = en & w_h_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CW     (CW)
    ) u_h_axis (
        .clk_25    (clk_25),
        .reset_n   (reset_n),
        .step      (en),
        .cnt       (w_h_cnt),
        .wrap      (w_h_wrap),
        .in_active (w_h_active),
        .in_sync   (w_h_in_sync)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CW     (CW)
    ) u_v_axis (
        .clk_25    (clk_25),
        .reset_n   (reset_n),
        .step      (w_v_step),
        .cnt       (w_v_cnt),
        .wrap      (w_v_wrap_unused),
        .in_active (w_v_active),
        .in_sync   (w_v_in_sync)
    );

    // Combinational decode of the current position
    logic          w_de;
    logic          w_line_start;
    logic          w_frame_start;

    assign w_de          = w_h_active & w_v_active;
    assign w_line_start  = (w_h_cnt == '0);
    assign w_frame_start = w_line_start & (w_v_cnt == '0);

    // Output register stage
    logic          r_h_sync;
    logic          r_v_sync;
    logic          r_de;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          r_line_start;
    logic          r_frame_start;

    always_ff @(posedge clk_25) begin
        if (!reset_n) begin
            r_h_sync      <= ~H_POL;
            r_v_sync      <= ~V_POL;
            r_de          <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (en) begin
            r_h_sync      <= w_h_in_sync ? H_POL : ~H_POL;
            r_v_sync      <= w_v_in_sync ? V_POL : ~V_POL;
            r_de          <= w_de;
            r_x           <= w_de ? w_h_cnt : '0;
            r_y           <= w_de ? w_v_cnt : '0;
            r_line_start  <= w_line_start;
            r_frame_start <= w_frame_start;
        end
    end

    assign h_sync      = r_h_sync;
    assign v_sync      = r_v_sync;
    assign de          = r_de;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
// Directed bench for vga_timing_gen. Two instances share one 25 MHz clock:
//   u_dflt  : default 640x480@60 geometry, active-low syncs (one line or so)
//   u_small : H 8/2/3/2, V 4/1/1/1, active-high syncs, CW=4, so whole frames
//             (15 x 7 = 105 cycles) fit in a short run.
// Outputs are sampled and inputs driven on the falling edge.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic clk_25 = 1'b0;
    always #20 clk_25 = ~clk_25;

    // Default-geometry instance
    logic       d_rst_n, d_en;
    logic       d_hs, d_vs, d_de, d_ls, d_fs;
    logic [9:0] d_x, d_y;

    vga_timing_gen u_dflt (
        .clk_25      (clk_25),
        .reset_n     (d_rst_n),
        .en          (d_en),
        .h_sync      (d_hs),
        .v_sync      (d_vs),
        .de          (d_de),
        .x           (d_x),
        .y           (d_y),
        .line_start  (d_ls),
        .frame_start (d_fs)
    );

    // Small-geometry instance
    logic       s_rst_n, s_en;
    logic       s_hs, s_vs, s_de, s_ls, s_fs;
    logic [3:0] s_x, s_y;

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .H_POL    (1'b1), .V_POL (1'b1), .CW (4)
    ) u_small (
        .clk_25      (clk_25),
        .reset_n     (s_rst_n),
        .en          (s_en),
        .h_sync      (s_hs),
        .v_sync      (s_vs),
        .de          (s_de),
        .x           (s_x),
        .y           (s_y),
        .line_start  (s_ls),
        .frame_start (s_fs)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed view of the small instance: {hs, vs, de, ls, fs, x[3:0], y[3:0]}
    logic [12:0] s_obs;
    assign s_obs = {s_hs, s_vs, s_de, s_ls, s_fs, s_x, s_y};

    // Expected small-instance outputs when they show raster position number idx
    // (idx counts positions from (0,0) in raster order).
    function automatic logic [12:0] s_model(input int idx);
        int   h;
        int   v;
        logic vis;
        h   = idx % 15;
        v   = (idx / 15) % 7;
        vis = (h < 8) && (v < 4);
        return {(h >= 10 && h < 13), (v == 5), vis, (h == 0), (h == 0 && v == 0),
                vis ? 4'(h) : 4'd0, vis ? 4'(v) : 4'd0};
    endfunction

    initial begin
        int first_low, last_low, h_low, vs_low, de_cnt, x_bad, ls_cnt, ls_second;
        int hs_hi, vs_hi, fs_cnt, k, cyc;
        logic [12:0] exp_v, prev_v;
        logic en_used;

        d_rst_n = 1'b0; d_en = 1'b1;
        s_rst_n = 1'b0; s_en = 1'b0;
        repeat (2) @(negedge clk_25);

        // Reset values
        check_val("d_rst_hs", d_hs, 1);
        check_val("d_rst_vs", d_vs, 1);
        check_val("d_rst_de", d_de, 0);
        check_val("d_rst_x",  d_x,  0);
        check_val("d_rst_y",  d_y,  0);
        check_val("d_rst_ls", d_ls, 0);
        check_val("d_rst_fs", d_fs, 0);
        check_val("s_rst",    s_obs, 13'h0);

        // ---------------- default geometry: first line + one cycle ----------
        d_rst_n = 1'b1;
        first_low = -1; last_low = -1; h_low = 0; vs_low = 0; de_cnt = 0;
        x_bad = 0; ls_cnt = 0; ls_second = 0;
        for (int c = 1; c <= 801; c++) begin
            @(negedge clk_25);
            if (c == 1) begin
                check_val("d_c1_fs", d_fs, 1);
                check_val("d_c1_ls", d_ls, 1);
                check_val("d_c1_de", d_de, 1);
                check_val("d_c1_xy", {d_x, d_y}, 20'h0);
            end
            if (c <= 800) begin
                if (!d_hs) begin
                    h_low++;
                    if (first_low < 0) first_low = c;
                    last_low = c;
                end
                if (!d_vs) vs_low++;
                if (d_de) begin
                    de_cnt++;
                    if (d_x != 10'(c - 1) || d_y != 10'd0) x_bad++;
                end
            end
            if (d_ls) begin
                ls_cnt++;
                if (c == 801) ls_second = 1;
            end
            if (c == 801) begin
                check_val("d_c801_y",  d_y,  1);
                check_val("d_c801_x",  d_x,  0);
                check_val("d_c801_fs", d_fs, 0);
                check_val("d_c801_de", d_de, 1);
            end
        end
        check_val("d_hs_low_len",   h_low,     96);
        check_val("d_hs_first_low", first_low, 657);
        check_val("d_hs_last_low",  last_low,  752);
        check_val("d_vs_low_line0", vs_low,    0);
        check_val("d_de_len",       de_cnt,    640);
        check_val("d_x_run_errs",   x_bad,     0);
        check_val("d_ls_count",     ls_cnt,    2);
        check_val("d_ls_at_801",    ls_second, 1);

        // en=0 freezes outputs, strobes included
        d_en = 1'b0;
        repeat (3) @(negedge clk_25);
        check_val("d_hold_ls", d_ls, 1);
        check_val("d_hold_xy", {d_x, d_y}, {10'd0, 10'd1});
        d_en = 1'b1;
        @(negedge clk_25);
        check_val("d_resume_x",  d_x,  1);
        check_val("d_resume_ls", d_ls, 0);

        // Mid-line reset, then restart from (0,0)
        d_rst_n = 1'b0;
        @(negedge clk_25);
        check_val("d_midrst_out", {d_hs, d_vs, d_de, d_ls, d_fs, d_x, d_y},
                  {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0});
        d_rst_n = 1'b1;
        @(negedge clk_25);
        check_val("d_midrst_fs", {d_fs, d_ls, d_de, d_x, d_y}, {3'b111, 20'h0});

        // ---------------- small geometry: two golden frames -----------------
        s_rst_n = 1'b1; s_en = 1'b1;
        hs_hi = 0; vs_hi = 0; fs_cnt = 0;
        for (int idx = 0; idx < 210; idx++) begin
            @(negedge clk_25);
            check_val("s_golden", s_obs, s_model(idx));
            if (s_hs) hs_hi++;
            if (s_vs) vs_hi++;
            if (s_fs) fs_cnt++;
            if (idx == 60) begin
                // (14,3) -> (0,4): first line below the visible area
                check_val("s_wrap_vis_end_de", s_de, 0);
                check_val("s_wrap_vis_end_ls", s_ls, 1);
            end
            if (idx == 105) begin
                // (14,6) -> (0,0)
                check_val("s_wrap_frame", {s_fs, s_x, s_y}, {1'b1, 8'h0});
            end
        end
        check_val("s_hs_high_cycles", hs_hi,  42);
        check_val("s_vs_high_cycles", vs_hi,  30);
        check_val("s_fs_pulses",      fs_cnt, 2);

        // ---------------- small geometry: random en over two frames ---------
        s_rst_n = 1'b0;
        @(negedge clk_25);
        check_val("s_rst2", s_obs, 13'h0);
        s_rst_n = 1'b1;
        s_en = 1'($urandom_range(0, 1));
        k = 0; cyc = 0; prev_v = 13'h0;
        while (k < 210 && cyc < 3000) begin
            en_used = s_en;
            @(negedge clk_25);
            cyc++;
            if (en_used) begin
                exp_v = s_model(k);
                k++;
            end else begin
                exp_v = prev_v;
            end
            check_val("s_en_toggle", s_obs, exp_v);
            prev_v = exp_v;
            s_en = 1'($urandom_range(0, 1));
        end
        if (k < 210) check_val("s_en_toggle_budget", k, 210);

        // ---------------- small geometry: mid-frame reset -------------------
        s_en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_25);
            check_val("s_pre_reset", s_obs, s_model(k));
            k++;
        end
        s_rst_n = 1'b0;
        @(negedge clk_25);
        check_val("s_midrst_out", s_obs, 13'h0);
        s_rst_n = 1'b1;
        for (int idx = 0; idx <= 105; idx++) begin
            @(negedge clk_25);
            check_val("s_after_reset", s_obs, s_model(idx));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
